// File: rtl/serial_parity_rx_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_parity_rx_pkg : FSM encodings and frame-format constants shared by
//                        the serial parity receiver and its transmitter.
// Revision 1.0
// ---------------------------------------------------------------------------
package serial_parity_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_parity_rx_xor_gate.sv
`default_nettype none
// ---------------------------------------------------------------------------
// XOR_GATE : two-input XOR cell used as the parity accumulator step.
// Revision 1.0
// ---------------------------------------------------------------------------
module XOR_GATE (
  input  logic in0,
  input  logic in1,
  output logic out
);

  assign out = in0 ^ in1;

endmodule
`default_nettype wire

// File: rtl/serial_parity_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_parity_rx : oversampled serial receiver with parity/stop checking,
//                    a held-frame register with ack handshake and overrun flag.
// Revision 1.0
// ---------------------------------------------------------------------------
module serial_parity_rx
  import serial_parity_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned BIT_CYCLES = 4,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in0,
  input  logic                 ack,
  output logic [DATA_BITS-1:0] out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(BIT_CYCLES);
  localparam int unsigned CW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_HALF   = TW'(BIT_CYCLES / 2 - 1);
  localparam logic [TW-1:0] T_FULL   = TW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q;
  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 par_next;
  logic                 tick;
  logic                 load;

  logic [DATA_BITS-1:0] out_q;
  logic                 valid_q, perr_q, ferr_q, ovr_q, busy_q;

  XOR_GATE u_par_xor (
    .in0 (par_q),
    .in1 (sync2_q),
    .out (par_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= LINE_IDLE;
      sync2_q  <= LINE_IDLE;
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
    end else begin
      sync1_q  <= in0;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    load     = 1'b0;
    tick     = (timer_q == '0);
    case (state_q)
      ST_IDLE: begin
        if (sync2_q == START_BIT) begin
          state_d = ST_START;
          timer_d = T_HALF;
        end
      end
      ST_START: begin
        if (!tick) begin
          timer_d = timer_q - TW'(1);
        end else if (sync2_q == START_BIT) begin
          state_d  = ST_DATA;
          timer_d  = T_FULL;
          bitcnt_d = '0;
          shift_d  = '0;
          par_d    = PARITY_ODD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!tick) begin
          timer_d = timer_q - TW'(1);
        end else begin
          // LSB arrives first, so shift right and insert at the top
          shift_d                = shift_q >> 1;
          shift_d[DATA_BITS-1]   = sync2_q;
          par_d                  = par_next;
          timer_d                = T_FULL;
          if (bitcnt_q == LAST_BIT) begin
            state_d  = ST_PARITY;
            bitcnt_d = '0;
          end else begin
            bitcnt_d = bitcnt_q + CW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (!tick) begin
          timer_d = timer_q - TW'(1);
        end else begin
          par_d   = par_next;
          timer_d = T_FULL;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!tick) begin
          timer_d = timer_q - TW'(1);
        end else begin
          load    = 1'b1;
          timer_d = T_FULL;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A load always wins over ack; ack on the load edge only suppresses overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= (state_d != ST_IDLE);
      if (load) begin
        out_q   <= shift_q;
        perr_q  <= par_q;
        ferr_q  <= (sync2_q != STOP_BIT);
        ovr_q   <= valid_q & ~ack;
        valid_q <= 1'b1;
      end else if (valid_q && ack) begin
        valid_q <= 1'b0;
        perr_q  <= 1'b0;
        ferr_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign out        = out_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: doc/serial_parity_rx.md
SERIAL_PARITY_RX -- requirements
Module: SERIAL_PARITY_RX

Interface
REQ-001 The block SHALL take parameter DATA_BITS, default 8: number of data bits per frame (range 1..16).
REQ-002 The block SHALL take parameter BIT_CYCLES, default 4: clock cycles per serial bit (even, range 2..256).
REQ-003 The block SHALL take parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in0, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The block SHALL have port ack, input, 1 bit: consumer acknowledge of the held frame.
REQ-008 The block SHALL have port out, output, DATA_BITS bits: last received data word.
REQ-009 The block SHALL have port valid, output, 1 bit: out and the flags hold an unacknowledged frame.
REQ-010 The block SHALL have port parity_err, output, 1 bit: the held frame failed the parity check.
REQ-011 The block SHALL have port frame_err, output, 1 bit: the held frame's stop bit sampled 0.
REQ-012 The block SHALL have port overrun, output, 1 bit: a frame was overwritten before ack.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 in0 SHALL pass through a 2-flop synchronizer (reset value 1) before any use; all sampling SHALL use the synchronized value.
REQ-015 The frame format SHALL be: start bit (0), DATA_BITS data bits LSB first, 1 parity bit, 1 stop bit (1).
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-017 IDLE->START SHALL occur on the first synchronized 0; the bit-timer SHALL load BIT_CYCLES/2-1.
REQ-018 START SHALL re-sample at timer expiry: 0 -> DATA with timer BIT_CYCLES-1; 1 (glitch) -> IDLE with no output change.
REQ-019 DATA SHALL sample one bit per BIT_CYCLES cycles at mid-bit, shifting it into the shift register, and go to PARITY after DATA_BITS samples.
REQ-020 The running parity SHALL be the XOR of all sampled data bits plus PARITY_ODD; the PARITY-state sample SHALL be XORed in, and a nonzero result SHALL mean parity error.
REQ-021 STOP SHALL sample mid-bit; a 0 SHALL set frame error for this frame. The FSM SHALL return to IDLE on the same edge, and no wait for the line to go high SHALL occur.
REQ-022 On the STOP sample edge, the block SHALL load out, parity_err and frame_err and set valid to 1 (latency 1 cycle from the stop sample).
REQ-023 If valid=1 and ack=0 on the load edge, the block SHALL overwrite the frame and set overrun=1, and overrun SHALL stay set until acked.
REQ-024 valid&ack with no load SHALL clear valid, parity_err, frame_err and overrun on the next edge, and out SHALL hold its value.
REQ-025 On a simultaneous load and ack, the new frame SHALL be loaded, valid SHALL stay 1, and overrun SHALL be 0.
REQ-026 ack while valid=0 SHALL be ignored.
REQ-027 The bit-timer SHALL be a down-counter; when it reaches 0 it SHALL reload, with no wrap beyond BIT_CYCLES-1.

Reset
REQ-028 While rst=1 at an edge, the FSM SHALL go to IDLE, the timer, bit counter, shift register and parity SHALL go to 0, and the synchronizer SHALL go to 1.
REQ-029 While rst=1 at an edge, out SHALL go to 0 and valid, parity_err, frame_err, overrun and busy SHALL go to 0.
REQ-030 A reset mid-frame SHALL discard the partial frame, and the first falling edge after rst deasserts SHALL start a new frame.

Structure
REQ-031 The FSM state encodings (3 bits) and the frame-format constants SHALL live in a shared include/package, and the matching transmitter SHALL reuse them.
REQ-032 The parity accumulator SHALL instantiate the existing XOR_GATE (in0=running parity, in1=sampled bit); no other sub-module SHALL be used.
REQ-033 The RTL SHALL contain no latches, and every output SHALL be registered.

Verification (DATA_BITS=8, BIT_CYCLES=4, PARITY_ODD=0)
REQ-034 A frame of 0xA5 with parity bit 0 and stop bit 1 SHALL produce out=0xA5, valid=1, parity_err=0, frame_err=0; ack SHALL then clear valid one cycle later.
REQ-035 A frame of 0x01 with parity bit 0 SHALL produce out=0x01 and parity_err=1.
REQ-036 A frame of 0x3C with stop bit 0 SHALL produce frame_err=1 and out=0x3C.
REQ-037 in0 low for 1 cycle (a glitch) SHALL produce no valid, and busy SHALL return to 0 within BIT_CYCLES/2+3 cycles.
REQ-038 Frames 0x11 then 0x22 with no ack SHALL produce out=0x22 and overrun=1; acking on the second load edge SHALL instead produce overrun=0.
REQ-039 rst pulsed mid-DATA of a frame, followed by 0x5A, SHALL produce all outputs 0 after reset, then out=0x5A with valid=1.
